// File: rtl/cursor_controller.sv
// cursor_controller: joystick-driven screen cursor with press/auto-repeat.
// A held direction steps once on the first frame tick and then waits
// REPEAT_DELAY ticks. After that it steps once every REPEAT_RATE ticks.
// Positions saturate at the screen edges by default. Define the macro
// CURSOR_WRAP_EN to make positions wrap around to the opposite edge instead.
module cursor_controller #(
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int STEP         = 4,
    parameter int REPEAT_DELAY = 10,
    parameter int REPEAT_RATE  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] direction,
    input  logic       dir_valid,
    input  logic       frame_tick,
    output logic [9:0] cursor_x,
    output logic [9:0] cursor_y,
    output logic       moved,
    output logic [3:0] at_edge
);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    localparam logic [10:0] STEP_W = 11'(STEP);
    localparam logic [10:0] W_EXT  = 11'(SCREEN_W);
    localparam logic [10:0] H_EXT  = 11'(SCREEN_H);
    localparam logic [9:0]  X_MAX  = 10'(SCREEN_W - 1);
    localparam logic [9:0]  Y_MAX  = 10'(SCREEN_H - 1);
    localparam logic [9:0]  X_MID  = 10'(SCREEN_W / 2);
    localparam logic [9:0]  Y_MID  = 10'(SCREEN_H / 2);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DELAY  = 2'b01,
        REPEAT = 2'b10
    } state_t;

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [1:0]       last_dir_r, last_dir_s;
    logic             step_s;
    logic [9:0]       next_x_s, next_y_s;
    logic             moved_s;

    // Increasing coordinate. The sum is formed at 11 bits so it cannot overflow before the range check.
    function automatic logic [9:0] step_up(input logic [9:0] pos, input logic [10:0] extent);
        logic [10:0] sum_v;
        sum_v = {1'b0, pos} + STEP_W;
        if (sum_v > (extent - 11'd1)) begin
`ifdef CURSOR_WRAP_EN
            return 10'(sum_v - extent);
`else
            return 10'(extent - 11'd1);
`endif
        end else begin
            return 10'(sum_v);
        end
    endfunction

    // Decreasing coordinate. Underflow is detected before subtracting.
    function automatic logic [9:0] step_down(input logic [9:0] pos, input logic [10:0] extent);
        if ({1'b0, pos} < STEP_W) begin
`ifdef CURSOR_WRAP_EN
            return 10'({1'b0, pos} + extent - STEP_W);
`else
            return 10'd0;
`endif
        end else begin
            return 10'({1'b0, pos} - STEP_W);
        end
    endfunction

    // Press / delay / auto-repeat sequencing. Decides on which ticks a step is taken.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        last_dir_s = last_dir_r;
        step_s     = 1'b0;
        if (!dir_valid) begin
            state_s = IDLE;
            cnt_s   = CNT_ZERO;
        end else if (frame_tick) begin
            case (state_r)
                IDLE: begin
                    step_s     = 1'b1;
                    last_dir_s = direction;
                    cnt_s      = CNT_ZERO;
                    state_s    = DELAY;
                end
                DELAY: begin
                    if (direction != last_dir_r) begin
                        step_s     = 1'b1;
                        last_dir_s = direction;
                        cnt_s      = CNT_ZERO;
                    end else if (cnt_r == DELAY_LAST) begin
                        step_s  = 1'b1;
                        cnt_s   = CNT_ZERO;
                        state_s = REPEAT;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                REPEAT: begin
                    if (direction != last_dir_r) begin
                        step_s     = 1'b1;
                        last_dir_s = direction;
                        cnt_s      = CNT_ZERO;
                        state_s    = DELAY;
                    end else if (cnt_r == RATE_LAST) begin
                        step_s = 1'b1;
                        cnt_s  = CNT_ZERO;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = CNT_ZERO;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Candidate position for this edge. A step always moves in the direction sampled on the tick.
    always_comb begin
        next_x_s = cursor_x;
        next_y_s = cursor_y;
        if (step_s) begin
            case (direction)
                2'b01:   next_x_s = step_up(cursor_x, W_EXT);
                2'b10:   next_x_s = step_down(cursor_x, W_EXT);
                2'b11:   next_y_s = step_down(cursor_y, H_EXT);
                2'b00:   next_y_s = step_up(cursor_y, H_EXT);
                default: next_x_s = cursor_x;
            endcase
        end else begin
            next_x_s = cursor_x;
        end
        moved_s = (next_x_s != cursor_x) || (next_y_s != cursor_y);
    end

    // Control state registers. Reset abandons any press that is in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            cnt_r      <= CNT_ZERO;
            last_dir_r <= 2'b00;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            last_dir_r <= last_dir_s;
        end
    end

    // Registered outputs. at_edge is derived from the position being loaded so it stays aligned with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            cursor_x <= X_MID;
            cursor_y <= Y_MID;
            moved    <= 1'b0;
            at_edge  <= 4'b0000;
        end else begin
            cursor_x <= next_x_s;
            cursor_y <= next_y_s;
            moved    <= moved_s;
            at_edge  <= {(next_y_s == 10'd0), (next_y_s == Y_MAX),
                         (next_x_s == 10'd0), (next_x_s == X_MAX)};
        end
    end

endmodule
